// File: rtl/sccomp_pkg.sv
// sccomp_pkg: shared encodings and default address map for the single-cycle SoC memory bridge.
package sccomp_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_UNMAPPED = 2'b10;
    localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'h1002_0000;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane merge for stores and lane extract/extend for loads.
module mem_lane_align
    import sccomp_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] merged,
    output logic [31:0] rdata,
    output logic        aligned
);
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] mask;
    logic [15:0] sh;
    always_comb begin
        aligned = size == SZ_BYTE || (size == SZ_HALF ? !lane[0] : lane == 2'b00);
        be = size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // replicate the right-aligned store data so every lane sees it, then keep only enabled lanes
        wrep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merged = (word & ~mask) | (wrep & mask);
        sh = 16'(word >> {lane, 3'b000});
        rdata = size == SZ_BYTE ? {{24{~unsigned_ld & sh[7]}}, sh[7:0]} :
                size == SZ_HALF ? {{16{~unsigned_ld & sh[15]}}, sh[15:0]} : word;
    end
endmodule

// File: rtl/sccomp_mem_bridge.sv
// sccomp_mem_bridge: CPU data RAM + display MMIO bridge with cpu_ce divider and sticky fault latch.
module sccomp_mem_bridge
    import sccomp_pkg::*;
#(
    parameter logic [31:0] DATA_BASE    = DEF_DATA_BASE,
    parameter int          DEPTH_WORDS  = 256,
    parameter logic [31:0] MMIO_BASE    = DEF_MMIO_BASE,
    parameter int          SEG_CHANNELS = 2,
    parameter int          CE_DIV       = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    output logic        cpu_ce,
    input  logic        dm_ena,
    input  logic        dm_r,
    input  logic        dm_w,
    input  logic [1:0]  dm_size,
    input  logic        dm_unsigned,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data_w,
    output logic [31:0] dm_data_out,
    input  logic [1:0]  disp_sel,
    output logic [31:0] disp_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CE_DIV - 1);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] MMIO_BYTES = 32'(SEG_CHANNELS * 4);
    localparam logic [2:0] NSEG = 3'(SEG_CHANNELS);
    logic [31:0]   ram [DEPTH_WORDS];
    logic [31:0]   disp_r [4];
    logic [31:0]   d_off, m_off, cur, merged, rdata;
    logic          ram_hit, mmio_hit, aligned, bad, acc, we;
    logic [AW-1:0] ram_idx;
    logic [1:0]    m_idx;
    logic [CW-1:0] cnt;
    always_comb begin
        d_off = dm_addr - DATA_BASE;
        m_off = dm_addr - MMIO_BASE;
        ram_hit = d_off < RAM_BYTES;
        mmio_hit = m_off < MMIO_BYTES;
        ram_idx = d_off[AW+1:2];
        m_idx = m_off[3:2];
        cur = ram_hit ? ram[ram_idx] : mmio_hit ? disp_r[m_idx] : '0;
        bad = !(ram_hit | mmio_hit) | !aligned;
        acc = cpu_ce & dm_ena & (dm_r | dm_w);
        we = cpu_ce & dm_ena & dm_w & !bad;
        dm_data_out = dm_ena & !bad ? rdata : '0;
        disp_data = {1'b0, disp_sel} < NSEG ? disp_r[disp_sel] : '0;
    end
    mem_lane_align u_align (
        .size        (dm_size),
        .lane        (dm_addr[1:0]),
        .unsigned_ld (dm_unsigned),
        .wdata       (dm_data_w),
        .word        (cur),
        .merged      (merged),
        .rdata       (rdata),
        .aligned     (aligned)
    );
    // RAM contents survive reset; only the write is suppressed
    always_ff @(posedge clk_in) begin
        if (!reset && we && ram_hit)
            ram[ram_idx] <= merged;
    end
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt <= '0;
            cpu_ce <= 1'b0;
            fault <= 1'b0;
            fault_cause <= FC_NONE;
            fault_addr <= '0;
            for (int i = 0; i < 4; i++)
                disp_r[i] <= '0;
        end else begin
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            cpu_ce <= cnt == LAST;
            if (acc && bad && !fault) begin
                fault <= 1'b1;
                fault_cause <= !(ram_hit | mmio_hit) ? FC_UNMAPPED : FC_MISALIGN;
                fault_addr <= dm_addr;
            end
            if (we && !ram_hit)
                disp_r[m_idx] <= merged;
        end
    end
endmodule

// File: doc/sccomp_mem_bridge.md
# sccomp_mem_bridge

Parametrised data-memory and MMIO bridge for the single-cycle SoC, sitting between `cpu` and the board-level display path. It translates CPU data addresses into a local RAM region and a bank of display registers. It performs little-endian byte/half/word stores with lane merging and sign- or zero-extending loads. It generates the CPU clock-enable and latches the first unmapped or misaligned access as a sticky fault.

## Interface
Parameters:
- `DATA_BASE`, 32'h1001_0000, CPU byte address of RAM word 0
- `DEPTH_WORDS`, 256, RAM depth in 32-bit words; power of two, 16..4096
- `MMIO_BASE`, 32'h1002_0000, CPU byte address of display register 0
- `SEG_CHANNELS`, 2, number of 32-bit display registers, 1..4
- `CE_DIV`, 4, `cpu_ce` period in `clk_in` cycles, ≥1

Ports:
- `clk_in` in 1, sole clock, rising edge
- `reset` in 1, synchronous, active-high
- `cpu_ce` out 1, one-cycle clock-enable pulse for CPU and bridge writes
- `dm_ena` in 1, access valid
- `dm_r` in 1, read request
- `dm_w` in 1, write request
- `dm_size` in 2, 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `dm_unsigned` in 1, zero-extend loads when 1
- `dm_addr` in 32, CPU byte address
- `dm_data_w` in 32, store data, right-aligned
- `dm_data_out` out 32, load data, extended
- `disp_sel` in 2, display register index
- `disp_data` out 32, selected display register; 0 if `disp_sel` ≥ `SEG_CHANNELS`
- `fault` out 1, sticky fault flag
- `fault_cause` out 2, 01 misaligned, 10 unmapped
- `fault_addr` out 32, `dm_addr` of the first fault

## Operation
- **Decode.** RAM hit when `dm_addr - DATA_BASE` < `DEPTH_WORDS*4` (unsigned, 32-bit wrap). MMIO hit when `dm_addr - MMIO_BASE` < `SEG_CHANNELS*4`. Any other address is unmapped.
- **Alignment.** Half requires `addr[0]==0`. Word requires `addr[1:0]==0`.
- **Lane selection.** Word index = offset[..:2]. Byte lane = `addr[1:0]`; half lane = `addr[1]`. Little-endian.
- **Store.** Commits on the `clk_in` edge where `cpu_ce & dm_ena & dm_w & hit & aligned`. Only the addressed lanes change: byte takes `dm_data_w[7:0]`, half takes `[15:0]`. MMIO stores use the same lane rules.
- **Load.** Combinational from `dm_addr` regardless of `cpu_ce`. The selected lane is sign-extended, or zero-extended when `dm_unsigned`. Unmapped, misaligned, or `dm_ena==0` reads return 0.
- **Simultaneous `dm_r` and `dm_w`.** Treated as a write. `dm_data_out` still shows pre-write data.
- **Fault detection.** Condition: `cpu_ce & dm_ena & (dm_r|dm_w) & (unmapped | misaligned)`. Unmapped takes precedence, giving cause 10.
- **Fault latch.** Only the first fault is latched into `fault`/`fault_cause`/`fault_addr`; later faults are ignored until `reset`. A faulting store modifies nothing.
- **`cpu_ce` generation.** A counter runs 0..`CE_DIV-1`. `cpu_ce` is registered and asserted in the cycle after the counter equals `CE_DIV-1`. With `CE_DIV=1`, `cpu_ce` is constantly 1 after reset.

## Timing
- **Reset values.** `cpu_ce`=0, counter=0, display registers=0, `fault`=0, `fault_cause`=0, `fault_addr`=0. RAM array is not reset and retains its contents.
- **First pulse.** `cpu_ce` first goes high `CE_DIV` cycles after the cycle in which `reset` is sampled low.
- **Read latency.** 0 cycles (asynchronous). Write latency is 1 edge; data is visible on reads in the following cycle.
- **Fault outputs.** Update on the same edge as the faulting access.
- **Reset during a `cpu_ce` cycle.** Reset wins: no write, no fault latched, counter restarts.
- **Display output.** `disp_data` is combinational from the registers and `disp_sel`.

## Structure
- Package `sccomp_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - cause encodings `FC_NONE`/`FC_MISALIGN`/`FC_UNMAPPED`
  - default base addresses
- Sub-module `mem_lane_align` (combinational):
  - computes byte-enables and store-merge data from size/`addr[1:0]`
  - extracts and extends load data
  - shared by the RAM and MMIO paths.
- The top contains the decode logic, the RAM array, the display registers, the fault latch and the `cpu_ce` counter.

## Test plan
- **`cpu_ce` period.** `CE_DIV=4`, release reset → `cpu_ce` high on cycles 4, 8, 12 after release; `CE_DIV=1` → high every cycle from cycle 1.
- **Word store/load.** SW 32'hA1B2C3D4 @0x10010008 → LW returns A1B2C3D4. SB 8'h80 @0x1001000B → LW returns 80B2C3D4, LB returns FFFFFF80, LBU returns 00000080.
- **Half-word store/load.** SH 16'hF00D @0x10010012 over word 0 → LW @0x10010010 returns F00D0000. LH @0x10010012 returns FFFFF00D, LHU returns 0000F00D.
- **MMIO.** SW 32'h12345678 @0x10020004 → `disp_sel=1` gives 12345678, `disp_sel=3` gives 0. SB 8'hFF @0x10020004 → `disp_sel=1` gives 123456FF.
- **Faults.** LW @0x10010002 → `fault`=1, cause 01, `fault_addr`=10010002. A following SW @0x00000000 leaves the cause at 01, and RAM/display remain unchanged.
- **Reset.** Reset asserted mid-run → display and fault fields clear. A RAM word written earlier still reads back its value.
